// File: rtl/half_rate_sched_pkg.sv
// Shared types and default widths for the derived-clock capture scheduler.
package half_rate_sched_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/half_rate_capture_sched_clk_div_phase.sv
// Phase counter and registered divided clock with edge strobes.
// clear forces the divided clock low (reporting a fall if it was high).
// en advances the phase by one clk cycle.
module clk_div_phase #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_q,
  output logic             clk_div,
  output logic             rise,
  output logic             fall,
  output logic             tick
);

  logic [DIV_W-1:0] phase;

  // A derived edge happens on the last clk cycle of each half-period.
  assign tick = en && (phase == div_q - DIV_W'(1));

  // Phase advance, toggle and single-cycle edge strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      clk_div <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (clear) begin
        phase   <= '0;
        clk_div <= 1'b0;
        fall    <= clk_div;
      end else if (en) begin
        if (tick) begin
          clk_div <= ~clk_div;
          rise    <= ~clk_div;
          fall    <= clk_div;
          phase   <= '0;
        end else begin
          phase <= phase + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/half_rate_capture_sched.sv
// Capture-run sequencer: IDLE -> RUN -> FINISH -> IDLE.
// Owns the run cycle counter, snapshot and done/err strobes; the divided
// clock itself lives in clk_div_phase.
module half_rate_capture_sched
  import half_rate_sched_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int MAX_CYC = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  output logic             busy,
  output logic             clk_div,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] cyc,
  output logic [CNT_W-1:0] snap,
  output logic             snap_valid,
  output logic             done,
  output logic             err
);

  state_e           state;
  logic [DIV_W-1:0] div_q;
  logic             accept;
  logic             term;
  logic             ph_en;
  logic             ph_clear;
  logic             tick;

  // Termination takes priority over any derived edge in the same cycle.
  assign accept   = (state == S_IDLE) && start && (div != '0);
  assign term     = stop || (cyc == CNT_W'(MAX_CYC));
  assign ph_en    = (state == S_RUN) && !term;
  assign ph_clear = accept || (state == S_FINISH);

  clk_div_phase #(.DIV_W(DIV_W)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .en      (ph_en),
    .clear   (ph_clear),
    .div_q   (div_q),
    .clk_div (clk_div),
    .rise    (rise),
    .fall    (fall),
    .tick    (tick)
  );

  // Run FSM, cycle counter, snapshot and status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      div_q      <= '0;
      busy       <= 1'b0;
      cyc        <= '0;
      snap       <= '0;
      snap_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_RUN;
            div_q <= div;
            cyc   <= '0;
            busy  <= 1'b1;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        S_RUN: begin
          if (term) begin
            state <= S_FINISH;
          end else begin
            cyc <= cyc + CNT_W'(1);
            if (tick) begin
              snap       <= cyc;
              snap_valid <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_half_rate_capture_sched.sv
// Self-checking bench: constant vector table, directed corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_half_rate_capture_sched;

  localparam int CNT_W   = 32;
  localparam int DIV_W   = 8;
  localparam int MAX_CYC = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] div;
  logic             busy, clk_div, rise, fall, snap_valid, done, err;
  logic [CNT_W-1:0] cyc, snap;

  half_rate_capture_sched #(.CNT_W(CNT_W), .DIV_W(DIV_W), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div),
    .busy(busy), .clk_div(clk_div), .rise(rise), .fall(fall),
    .cyc(cyc), .snap(snap), .snap_valid(snap_valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: derived-edge timing is computed from the run cycle
  // count (an edge whenever the count reaches a multiple of the ratio).
  int          m_mode;   // 0 idle, 1 running, 2 finishing
  int unsigned m_cyc, m_snap, m_divq;
  bit          m_busy, m_clk, m_rise, m_fall, m_sv, m_done, m_err;

  function automatic void model_reset();
    m_mode = 0; m_cyc = 0; m_snap = 0; m_divq = 0;
    m_busy = 0; m_clk = 0; m_rise = 0; m_fall = 0; m_sv = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    m_rise = 0; m_fall = 0; m_sv = 0; m_done = 0; m_err = 0;
    case (m_mode)
      0: if (start) begin
           if (div != 0) begin
             m_mode = 1; m_divq = div; m_cyc = 0; m_busy = 1; m_clk = 0;
           end else m_err = 1;
         end
      1: if (stop || m_cyc == MAX_CYC) m_mode = 2;
         else begin
           m_cyc++;
           if (m_cyc % m_divq == 0) begin
             m_snap = m_cyc - 1;
             m_sv   = 1;
             m_clk  = ((m_cyc / m_divq) % 2) == 1;
             m_rise = m_clk;
             m_fall = !m_clk;
           end
         end
      default: begin
         m_fall = m_clk; m_clk = 0; m_done = 1; m_busy = 0; m_mode = 0;
      end
    endcase
  endfunction

  task automatic check_model();
    chk("busy", busy, m_busy);
    chk("clk_div", clk_div, m_clk);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("cyc", cyc, m_cyc);
    chk("snap", snap, m_snap);
    chk("snap_valid", snap_valid, m_sv);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("rise_and_fall", rise & fall, 0);
    if (!busy) chk("clk_div_idle", clk_div, 0);
  endtask

  int n_rise, n_fall, n_done;

  // One clk edge: model follows the inputs sampled at the edge, outputs
  // are compared 1ns later.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    check_model();
    n_rise += int'(rise);
    n_fall += int'(fall);
    n_done += int'(done);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " clk_div"}, clk_div, 0);
    chk({tag, " rise"}, rise, 0);
    chk({tag, " fall"}, fall, 0);
    chk({tag, " cyc"}, cyc, 0);
    chk({tag, " snap"}, snap, 0);
    chk({tag, " snap_valid"}, snap_valid, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err, 0);
  endtask

  typedef struct {
    bit          start, stop;
    logic [7:0]  div;
    bit          busy, clk_div, rise, fall, done, err, sv;
    int unsigned cyc, snap;
  } vec_t;

  vec_t        tbl[10];
  int unsigned q_snap[$];
  int unsigned exp_s;

  initial begin
    // start, stop, div | busy, clk_div, rise, fall, done, err, sv | cyc, snap
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};  // div==0 rejected
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0};  // run starts, div 4
    tbl[3] = '{0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[4] = '{0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 2, 0};
    tbl[5] = '{0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 3, 0};
    tbl[6] = '{0, 0, 9, 1, 1, 1, 0, 0, 0, 1, 4, 3};  // first derived edge
    tbl[7] = '{0, 1, 9, 1, 1, 0, 0, 0, 0, 0, 4, 3};  // stop while clk_div high
    tbl[8] = '{0, 0, 9, 0, 0, 0, 1, 1, 0, 0, 4, 3};  // fall + done together
    tbl[9] = '{0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 4, 3};

    rst = 1; start = 0; stop = 0; div = '0;
    model_reset();
    n_rise = 0; n_fall = 0; n_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;

    // Vector table: err on div==0, then div=4 run stopped with clk_div high.
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; div = tbl[i].div;
      step();
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d clk_div", i), clk_div, tbl[i].clk_div);
      chk($sformatf("vec%0d rise", i), rise, tbl[i].rise);
      chk($sformatf("vec%0d fall", i), fall, tbl[i].fall);
      chk($sformatf("vec%0d done", i), done, tbl[i].done);
      chk($sformatf("vec%0d err", i), err, tbl[i].err);
      chk($sformatf("vec%0d snap_valid", i), snap_valid, tbl[i].sv);
      chk($sformatf("vec%0d cyc", i), cyc, tbl[i].cyc);
      chk($sformatf("vec%0d snap", i), snap, tbl[i].snap);
    end
    stop = 0;

    // div=1: toggle every edge, snaps 0..99, auto-termination at MAX_CYC.
    div = 1; start = 1; step(); start = 0;
    n_rise = 0; n_fall = 0; n_done = 0; exp_s = 0;
    for (int i = 0; i < 102; i++) begin
      step();
      if (snap_valid) begin
        chk("t1 snap_seq", snap, exp_s);
        exp_s++;
      end
    end
    chk("t1 snap_count", exp_s, 100);
    chk("t1 edge_count", n_rise + n_fall, 100);
    chk("t1 done_count", n_done, 1);
    chk("t1 final_cyc", cyc, 100);
    step();

    // div=3: edges every 3 cycles, snaps 2,5,8,...
    div = 3; start = 1; step(); start = 0;
    q_snap.delete();
    n_rise = 0; n_fall = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (snap_valid) q_snap.push_back(snap);
    end
    chk("t2 snap_count", q_snap.size(), 10);
    if (q_snap.size() >= 3) begin
      chk("t2 snap0", q_snap[0], 2);
      chk("t2 snap1", q_snap[1], 5);
      chk("t2 snap2", q_snap[2], 8);
    end
    chk("t2 rise_count", n_rise, 5);
    chk("t2 fall_count", n_fall, 5);
    stop = 1; step(); stop = 0;
    step(); step();

    // Async reset mid-run, then restart with div=2.
    div = 5; start = 1; step(); start = 0;
    repeat (7) step();
    chk("t5 clk_div_before_rst", clk_div, 1);
    #3 rst = 1;
    #1 model_reset();
    check_all_zero("t5 async");
    step();
    rst = 0;
    div = 2; start = 1; step(); start = 0;
    step(); step();
    chk("t5 first_sv", snap_valid, 1);
    chk("t5 first_snap", snap, 1);
    stop = 1; step(); stop = 0;
    step(); step();

    // start held and div changed during RUN; stop coincides with MAX_CYC.
    div = 2; start = 1; step();
    n_rise = 0; n_fall = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) div = 7;
      step();
    end
    chk("t6 edge_count", n_rise + n_fall, 50);
    chk("t6 cyc_at_max", cyc, 100);
    start = 0; stop = 1; n_done = 0;
    step(); step(); step();
    chk("t6 done_count", n_done, 1);
    stop = 0;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 4) == 0;
      stop  = ($urandom % 16) == 0;
      div   = DIV_W'($urandom_range(0, 5));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
